sram_arb_ctrl: RTL and testbench

- Controller that shares one single-port sram_w16_64 instance (64-bit, 4-bit address, 8 populated entries, active-low CEN/WEN, registered Q, 1-cycle read latency) between two requesters.
- Zero-fills the array after reset or on CLEAR, then arbitrates read/write requests round-robin with valid/ready handshakes.
- Returns read data with a per-requester valid strobe.
- Sits between the SRAM macro and its two clients, for example the L0 loader and the output/psum drain.

---
 rtl/sram_arb_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram_arb_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl
//   Shares one single-port SRAM macro (active-low CEN/WEN, registered Q,
//   one-cycle read latency) between two requesters. After reset or CLEAR the
//   populated entries are zero-filled. The controller then arbitrates
//   round-robin between the requesters using valid/ready handshakes.
//
// Ports
//   CLK, RESET_N        clock, asynchronous active-low reset
//   CLEAR               synchronous request to re-run the zero-fill
//   INIT_DONE           high while the controller is serving requests
//   VALIDn/WRn/ADDRn/WDATAn/READYn   requester n request channel
//   RVALIDn, RDATA      read response; RDATA is shared by both requesters
//   ERR                 one-cycle pulse after an out-of-range request is accepted
//   SRAM_CEN/WEN/A/D/Q  macro interface
module sram_arb_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CLEAR,
  output logic              INIT_DONE,
  input  logic              VALID0,
  input  logic              WR0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              READY0,
  output logic              RVALID0,
  input  logic              VALID1,
  input  logic              WR1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              READY1,
  output logic              RVALID1,
  output logic [DATA_W-1:0] RDATA,
  output logic              ERR,
  output logic              SRAM_CEN,
  output logic              SRAM_WEN,
  output logic [ADDR_W-1:0] SRAM_A,
  output logic [DATA_W-1:0] SRAM_D,
  input  logic [DATA_W-1:0] SRAM_Q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
  // One extra bit so the range check also works when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                last_q, last_d;    // 1 = requester 1 was granted last
  logic                rd_pend_q, rd_pend_d;
  logic                rd_req_q, rd_req_d;
  logic                rd_oor_q, rd_oor_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   a_q;               // last address driven to the macro
  logic [DATA_W-1:0]   d_q;               // last data driven to the macro

  logic                run;
  logic                gnt0, gnt1, gnt_any;
  logic                sel_wr, sel_oor;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                cen_c, wen_c;
  logic [ADDR_W-1:0]   a_c;
  logic [DATA_W-1:0]   d_c;

  // CLEAR takes priority over any request, so no grant is issued on that cycle.
  assign run      = (state_q == ST_RUN) && !CLEAR;
  assign gnt0     = run && VALID0 && (!VALID1 || last_q);
  assign gnt1     = run && VALID1 && (!VALID0 || !last_q);
  assign gnt_any  = gnt0 || gnt1;
  assign sel_wr    = gnt1 ? WR1    : WR0;
  assign sel_addr  = gnt1 ? ADDR1  : ADDR0;
  assign sel_wdata = gnt1 ? WDATA1 : WDATA0;
  assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    rd_pend_d = 1'b0;
    rd_req_d  = rd_req_q;
    rd_oor_d  = 1'b0;
    err_d     = 1'b0;
    cen_c     = 1'b1;
    wen_c     = 1'b1;
    a_c       = a_q;
    d_c       = d_q;
    case (state_q)
      ST_INIT: begin
        cen_c = 1'b0;
        wen_c = 1'b0;
        a_c   = cnt_q;
        d_c   = '0;
        if (CLEAR) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (CLEAR) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (gnt_any) begin
          last_d    = gnt1;
          err_d     = sel_oor;
          rd_pend_d = !sel_wr;
          rd_req_d  = gnt1;
          rd_oor_d  = sel_oor;
          // Out-of-range requests are accepted but never reach the macro.
          if (!sel_oor) begin
            cen_c = 1'b0;
            wen_c = !sel_wr;
            a_c   = sel_addr;
            d_c   = sel_wdata;
          end
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      rd_pend_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_req_q  <= rd_req_d;
      rd_oor_q  <= rd_oor_d;
      err_q     <= err_d;
    end
  end

  // Address/data hold registers: only meaningful while the macro is idle.
  always_ff @(posedge CLK) begin
    if (!cen_c) begin
      a_q <= a_c;
      d_q <= d_c;
    end
  end

  assign READY0    = gnt0;
  assign READY1    = gnt1;
  assign INIT_DONE = (state_q == ST_RUN);
  assign ERR       = err_q;
  assign RVALID0   = rd_pend_q && !rd_req_q;
  assign RVALID1   = rd_pend_q &&  rd_req_q;
  assign RDATA     = rd_oor_q ? '0 : SRAM_Q;
  // The macro must stay deselected for the whole time reset is held.
  assign SRAM_CEN  = RESET_N ? cen_c : 1'b1;
  assign SRAM_WEN  = RESET_N ? wen_c : 1'b1;
  assign SRAM_A    = a_c;
  assign SRAM_D    = d_c;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
module tb_sram_arb_ctrl;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;

  logic              CLK = 1'b0;
  logic              RESET_N, CLEAR, INIT_DONE;
  logic              VALID0, WR0, READY0, RVALID0;
  logic              VALID1, WR1, READY1, RVALID1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] WDATA0, WDATA1, RDATA;
  logic              ERR, SRAM_CEN, SRAM_WEN;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_D, SRAM_Q;

  sram_arb_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .INIT_DONE(INIT_DONE),
    .VALID0(VALID0), .WR0(WR0), .ADDR0(ADDR0), .WDATA0(WDATA0),
    .READY0(READY0), .RVALID0(RVALID0),
    .VALID1(VALID1), .WR1(WR1), .ADDR1(ADDR1), .WDATA1(WDATA1),
    .READY1(READY1), .RVALID1(RVALID1),
    .RDATA(RDATA), .ERR(ERR),
    .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A),
    .SRAM_D(SRAM_D), .SRAM_Q(SRAM_Q)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port macro: registered Q, one-cycle read latency.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = {$urandom, $urandom} | 64'h1;
  always @(posedge CLK) begin
    if (!SRAM_CEN) begin
      if (!SRAM_WEN) mem[SRAM_A] <= SRAM_D;
      else           SRAM_Q      <= mem[SRAM_A];
    end
  end

  typedef struct {
    logic              req;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           exp_q[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  int                n_checks = 0;
  int                n_fail   = 0;

  localparam logic [DATA_W-1:0] PAT_A = 64'h0123456789ABCDEF;
  localparam logic [DATA_W-1:0] PAT_B = 64'hFEDCBA9876543210;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic accept(input logic req, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, inout logic err);
    rd_exp_t e;
    logic    oor;
    oor = (int'(addr) >= DEPTH);
    if (oor) err = 1'b1;
    if (!wr) begin
      e.req  = req;
      e.data = oor ? '0 : ref_mem[addr[2:0]];
      exp_q.push_back(e);
    end else if (!oor) begin
      ref_mem[addr[2:0]] = wdata;
    end
  endtask

  // Called with inputs settled between edges: records handshakes, crosses
  // the next rising edge, then checks the registered response outputs.
  task automatic tick();
    rd_exp_t e;
    logic    nxt_err;
    nxt_err = 1'b0;
    if (READY0 && READY1) check("ready_both", 64'({READY1, READY0}), 64'd0);
    if (VALID0 && READY0) accept(1'b0, WR0, ADDR0, WDATA0, nxt_err);
    if (VALID1 && READY1) accept(1'b1, WR1, ADDR1, WDATA1, nxt_err);
    @(posedge CLK);
    #1;
    check("err", 64'(ERR), 64'(nxt_err));
    if (RVALID0 || RVALID1) begin
      if (exp_q.size() == 0) begin
        check("rvalid_spurious", 64'({RVALID1, RVALID0}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid0", 64'(RVALID0), 64'(!e.req));
        check("rvalid1", 64'(RVALID1), 64'(e.req));
        check("rdata", RDATA, e.data);
      end
    end else if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rvalid_missing", 64'({RVALID1, RVALID0}), e.req ? 64'd2 : 64'd1);
    end
  endtask

  task automatic idle();
    VALID0 = 1'b0;
    VALID1 = 1'b0;
    CLEAR  = 1'b0;
  endtask

  // Zero-fill sequence from count 0; a pending VALID0 must not be granted.
  task automatic init_seq();
    VALID0 = 1'b1;
    WR0    = 1'b0;
    ADDR0  = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("init_cen", 64'(SRAM_CEN), 64'd0);
      check("init_wen", 64'(SRAM_WEN), 64'd0);
      check("init_a", 64'(SRAM_A), 64'(i));
      check("init_d", SRAM_D, 64'd0);
      check("init_ready0", 64'(READY0), 64'd0);
      check("init_done_low", 64'(INIT_DONE), 64'd0);
      tick();
    end
    VALID0 = 1'b0;
    check("init_done_high", 64'(INIT_DONE), 64'd1);
  endtask

  task automatic req(input logic r, input logic wr, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d);
    if (!r) begin VALID0 = 1'b1; WR0 = wr; ADDR0 = a; WDATA0 = d; VALID1 = 1'b0; end
    else    begin VALID1 = 1'b1; WR1 = wr; ADDR1 = a; WDATA1 = d; VALID0 = 1'b0; end
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR = 1'b0;
    VALID0 = 1'b0; WR0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
    VALID1 = 1'b0; WR1 = 1'b0; ADDR1 = '0; WDATA1 = '0;
    clear_ref();
    #1;
    check("rst_cen", 64'(SRAM_CEN), 64'd1);
    check("rst_wen", 64'(SRAM_WEN), 64'd1);
    check("rst_rvalid", 64'({RVALID1, RVALID0}), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_init_done", 64'(INIT_DONE), 64'd0);
    tick();
    tick();
    RESET_N = 1'b1;
    init_seq();

    // Write then immediately read back the same address.
    req(1'b0, 1'b1, 4'd3, PAT_A);
    #1;
    check("wr_ready0", 64'(READY0), 64'd1);
    check("wr_cen", 64'(SRAM_CEN), 64'd0);
    check("wr_wen", 64'(SRAM_WEN), 64'd0);
    check("wr_a", 64'(SRAM_A), 64'd3);
    check("wr_d", SRAM_D, PAT_A);
    tick();
    req(1'b0, 1'b0, 4'd3, '0);
    #1;
    check("rd_ready0", 64'(READY0), 64'd1);
    check("rd_wen", 64'(SRAM_WEN), 64'd1);
    tick();
    req(1'b0, 1'b0, 4'd5, '0);
    #1;
    tick();
    // Highest in-range address.
    req(1'b0, 1'b1, 4'd7, PAT_B);
    #1;
    tick();
    req(1'b0, 1'b0, 4'd7, '0);
    #1;
    tick();
    // First out-of-range address, as a write: accepted, macro untouched.
    req(1'b0, 1'b1, 4'd8, PAT_B);
    #1;
    check("oorw_ready0", 64'(READY0), 64'd1);
    check("oorw_cen", 64'(SRAM_CEN), 64'd1);
    check("oorw_a_hold", 64'(SRAM_A), 64'd7);
    tick();
    // Out-of-range read from requester 1.
    req(1'b1, 1'b0, 4'd12, '0);
    #1;
    check("oorr_ready1", 64'(READY1), 64'd1);
    check("oorr_cen", 64'(SRAM_CEN), 64'd1);
    tick();
    idle();
    #1;
    check("idle_cen", 64'(SRAM_CEN), 64'd1);
    tick();

    // Both requesters reading continuously: grants alternate from 0.
    VALID0 = 1'b1; WR0 = 1'b0; ADDR0 = 4'd3;
    VALID1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd7;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rr_ready0", 64'(READY0), 64'((k % 2) == 0));
      check("rr_ready1", 64'(READY1), 64'((k % 2) == 1));
      tick();
    end
    idle();
    #1;
    tick();

    // CLEAR in RUN beats a pending request and re-runs the zero-fill.
    req(1'b0, 1'b0, 4'd3, '0);
    CLEAR = 1'b1;
    #1;
    check("clr_ready0", 64'(READY0), 64'd0);
    check("clr_cen", 64'(SRAM_CEN), 64'd1);
    clear_ref();
    tick();
    CLEAR = 1'b0;
    init_seq();
    req(1'b0, 1'b0, 4'd3, '0);
    #1;
    tick();
    req(1'b1, 1'b0, 4'd7, '0);
    #1;
    tick();
    idle();
    #1;
    tick();

    // Reset dropped part-way through a zero-fill.
    CLEAR = 1'b1;
    #1;
    tick();
    CLEAR = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mid_a", 64'(SRAM_A), 64'(i));
      tick();
    end
    #1;
    check("mid4_cen", 64'(SRAM_CEN), 64'd0);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_cen", 64'(SRAM_CEN), 64'd1);
    check("mid_rst_wen", 64'(SRAM_WEN), 64'd1);
    tick();
    RESET_N = 1'b1;
    clear_ref();
    init_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
